// File: rtl/dbus_sram.sv
// Data-bus slave backed by a word-organised synchronous RAM with configurable wait states.
// Define DBUS_SRAM_ERR_EN to fault misaligned, reserved-size and out-of-range accesses.
module dbus_sram #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dbus_en,
   input  logic        dbus_we,
   input  logic [1:0]  dbus_size,
   input  logic [31:0] dbus_addr,
   input  logic [31:0] dbus_data,
   output logic [31:0] dbus_rdata,
   output logic        dbus_stall,
   output logic        dbus_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        access;
   logic        fault;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic [31:0]   rword;
   logic [31:0]   load_data;

   assign idx = dbus_addr[AW+1:2];

`ifdef DBUS_SRAM_ERR_EN
   assign fault = (dbus_size == 2'b01 && dbus_addr[0])
               || (dbus_size == 2'b10 && dbus_addr[1:0] != 2'b00)
               || (dbus_size == 2'b11)
               || ((dbus_addr >> (AW + 2)) != 32'd0);
`else
   // Upper address bits are don't-care: accesses wrap modulo the array size.
   logic unused_addr;
   assign unused_addr = ^dbus_addr[31:AW+2];
   assign fault       = 1'b0;
`endif

   always_comb begin
      lane  = 2'b00;
      be    = 4'b1111;
      wdata = dbus_data;
      unique case (dbus_size)
         2'b00: begin
            lane  = dbus_addr[1:0];
            be    = 4'b0001 << dbus_addr[1:0];
            wdata = {4{dbus_data[7:0]}};
         end
         2'b01: begin
            lane  = {dbus_addr[1], 1'b0};
            be    = dbus_addr[1] ? 4'b1100 : 4'b0011;
            wdata = {2{dbus_data[15:0]}};
         end
         default: ;
      endcase
   end

   assign rword = mem[idx];

   always_comb begin
      load_data = rword >> {lane, 3'b000};
      unique case (dbus_size)
         2'b00:   load_data = load_data & 32'h0000_00ff;
         2'b01:   load_data = load_data & 32'h0000_ffff;
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      access  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (dbus_en) begin
               if (WAIT_CYCLES == 0) begin
                  access  = 1'b1;
                  state_d = StDone;
               end else begin
                  cnt_d   = 4'(WAIT_CYCLES);
                  state_d = StWait;
               end
            end
         end
         // Completes even if dbus_en is withdrawn.
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               access  = 1'b1;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      err_d   = err_q;
      if (access) begin
         rdata_d = (dbus_we || fault) ? 32'd0 : load_data;
         err_d   = fault;
      end else if (state_q == StDone) begin
         err_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // RAM is not reset; writes are blocked while reset is held.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst_n && access && dbus_we && !fault && be[i]) begin
            mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign dbus_rdata = rdata_q;
   assign dbus_err   = err_q;
   assign dbus_stall = dbus_en & (state_q != StDone);

endmodule
